// File: rtl/serializer_gearbox.sv
// Parallel-to-serial gearbox: CHANNELS lanes of DIN_W-bit words out as OUT_W-bit slices per clock.
// Latency: slice 0 appears one cycle after the load edge (phase RATIO-1) that takes the word.
// Backpressure: one-word holding buffer; din_ready drops while it is full, except in the load phase.
module serializer_gearbox #(
  parameter int               DIN_W     = 10,
  parameter int               OUT_W     = 2,
  parameter int               CHANNELS  = 3,
  parameter int               MSB_FIRST = 0,
  parameter logic [DIN_W-1:0] IDLE_WORD = 10'b1101010100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*DIN_W-1:0] din,
  input  logic                      din_valid,
  output logic                      din_ready,
  output logic [CHANNELS*OUT_W-1:0] dout,
  output logic                      dout_first,
  output logic                      underflow,
  input  logic                      underflow_clr
);

  localparam int RATIO = DIN_W / OUT_W;
  localparam int PH_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(RATIO - 1);

  logic [PH_W-1:0]           phase;
  logic [CHANNELS*DIN_W-1:0] sh;
  logic [CHANNELS*DIN_W-1:0] sh_shifted;
  logic [CHANNELS*DIN_W-1:0] hold;
  logic                      hold_valid;
  logic                      load;
  logic                      accept;
  logic [DIN_W-1:0]          lane_word;

  assign load       = (phase == LAST_PH);
  assign din_ready  = !hold_valid || load;
  assign accept     = din_valid && din_ready;
  assign dout_first = (phase == '0);

  // Per-lane shift toward the end being transmitted, plus slice extraction.
  always_comb begin
    sh_shifted = '0;
    dout       = '0;
    lane_word  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      lane_word = sh[c*DIN_W +: DIN_W];
      if (MSB_FIRST != 0) begin
        sh_shifted[c*DIN_W +: DIN_W] = lane_word << OUT_W;
        for (int k = 0; k < OUT_W; k++) begin
          dout[c*OUT_W + k] = lane_word[DIN_W-1-k];
        end
      end else begin
        sh_shifted[c*DIN_W +: DIN_W] = lane_word >> OUT_W;
        dout[c*OUT_W +: OUT_W]       = lane_word[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= '0;
      sh         <= {CHANNELS{IDLE_WORD}};
      hold       <= '0;
      hold_valid <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      phase <= load ? '0 : phase + PH_W'(1);

      if (load) begin
        if (hold_valid) begin
          sh <= hold;
          if (accept) begin
            hold <= din;
          end else begin
            hold_valid <= 1'b0;
          end
        end else if (accept) begin
          sh <= din;
        end else begin
          sh <= {CHANNELS{IDLE_WORD}};
        end
      end else begin
        sh <= sh_shifted;
        if (accept) begin
          hold       <= din;
          hold_valid <= 1'b1;
        end
      end

      // A fresh underflow outranks a simultaneous clear so no event is lost.
      if (load && !hold_valid && !accept) begin
        underflow <= 1'b1;
      end else if (underflow_clr) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serializer_gearbox.sv
// Bench for serializer_gearbox: default instance checked every cycle against a word scoreboard,
// plus MSB-first and 1-bit-wide instances checked on directed bit patterns.
module tb_serializer_gearbox;

  localparam int R = 5;
  localparam logic [9:0] IDLE = 10'b1101010100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [5:0]  dout;
  logic        dout_first;
  logic        underflow;
  logic        clr = 1'b0;

  logic [9:0]  din_m = 10'b1000000001;
  logic        rdy_m, first_m, uf_m;
  logic [1:0]  dout_m;
  logic [9:0]  din_b = 10'h2B5;
  logic        rdy_b, first_b, uf_b;
  logic [0:0]  dout_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serializer_gearbox dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_first(dout_first), .underflow(underflow), .underflow_clr(clr)
  );

  serializer_gearbox #(.CHANNELS(1), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .din(din_m), .din_valid(1'b1), .din_ready(rdy_m),
    .dout(dout_m), .dout_first(first_m), .underflow(uf_m), .underflow_clr(1'b0)
  );

  serializer_gearbox #(.OUT_W(1), .CHANNELS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(1'b1), .din_ready(rdy_b),
    .dout(dout_b), .dout_first(first_b), .underflow(uf_b), .underflow_clr(1'b0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bench-side phase of the current cycle, as seen after each rising edge.
  logic [2:0] tph;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tph <= 3'd0;
    else        tph <= (tph == 3'(R-1)) ? 3'd0 : tph + 3'd1;
  end

  // Scoreboard: accepted word sets queue up; each dout_first starts the oldest one, or IDLE.
  logic [29:0] q[$];
  logic [29:0] cur_w;
  bit          uf_exp;
  bit          rdy_exp;
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      uf_exp = 1'b0;
      cur_w  = {3{IDLE}};
    end else begin
      if (tph == 3'd0) cur_w = (q.size() > 0) ? q.pop_front() : {3{IDLE}};
      for (int c = 0; c < 3; c++)
        chk($sformatf("dout_ch%0d_ph%0d", c, tph), 32'(dout[c*2 +: 2]), 32'(cur_w[c*10 + tph*2 +: 2]));
      chk("dout_first", 32'(dout_first), 32'(tph == 3'd0));
      rdy_exp = (q.size() == 0) || (tph == 3'(R-1));
      chk("din_ready", 32'(din_ready), 32'(rdy_exp));
      chk("underflow", 32'(underflow), 32'(uf_exp));
      if (din_valid && rdy_exp) q.push_back(din);
      if (tph == 3'(R-1) && q.size() == 0) uf_exp = 1'b1;
      else if (clr)                        uf_exp = 1'b0;
    end
  end

  task automatic send(input logic [29:0] w);
    bit acc;
    acc = 1'b0;
    din = w;
    din_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = din_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed no accept expected accept within 20 cycles");
    end
  endtask

  task automatic wait_ph(input logic [2:0] p);
    for (int i = 0; i < 12; i++) begin
      if (tph == p) break;
      @(posedge clk); #1;
    end
    chk("wait_phase", 32'(tph), 32'(p));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din_valid = 1'b0;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [1:0] msb_exp [5];
  logic       bit_exp [10];
  int         nfirst;
  bit         found;

  initial begin
    msb_exp = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    bit_exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_din_ready", 32'(din_ready), 32'h1);
    chk("rst_dout_first", 32'(dout_first), 32'h1);
    chk("rst_underflow", 32'(underflow), 32'h0);
    chk("rst_dout_msb", 32'(dout_m), 32'h3);
    chk("rst_dout_bit", 32'(dout_b), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // MSB-first instance: first real word follows one idle word
    @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (first_m) begin found = 1'b1; break; end
    end
    chk("msb_first_seen", 32'(found), 32'h1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("msb_slice%0d", k), 32'(dout_m), 32'(msb_exp[k]));
      @(negedge clk);
    end

    // OUT_W = 1 instance: bit stream and once-per-word dout_first
    found = 1'b0;
    for (int i = 0; i < 22; i++) begin
      if (first_b) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("bit_first_seen", 32'(found), 32'h1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bit%0d", k), 32'(dout_b), 32'(bit_exp[k]));
      @(negedge clk);
    end
    nfirst = 0;
    for (int i = 0; i < 30; i++) begin
      if (first_b) nfirst++;
      @(negedge clk);
    end
    chk("bit_first_count", 32'(nfirst), 32'd3);

    // Underflow clear: set wins in a load cycle, clear works elsewhere
    @(posedge clk); #1;
    chk("uf_idle_set", 32'(underflow), 32'h1);
    wait_ph(3'd4);
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    chk("uf_clr_at_load", 32'(underflow), 32'h1);
    wait_ph(3'd1);
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    chk("uf_clr_mid", 32'(underflow), 32'h0);
    repeat (6) @(posedge clk);
    #1;

    // Bypass: first valid arrives in the load cycle
    do_reset();
    @(posedge clk); #1;
    wait_ph(3'd4);
    din = {3{10'h001}};
    din_valid = 1'b1;
    @(posedge clk); #1 din_valid = 1'b0;
    chk("byp_first", 32'(dout_first), 32'h1);
    chk("byp_slice0", 32'(dout), 32'(6'b010101));
    chk("byp_no_uf", 32'(underflow), 32'h0);
    repeat (12) @(posedge clk);
    #1;

    // Continuous stream from reset release
    do_reset();
    for (int n = 0; n < 6; n++) send({10'h2AA, 10'h000, 10'h3FF});
    din_valid = 1'b0;
    chk("stream_no_uf", 32'(underflow), 32'h0);
    repeat (12) @(posedge clk);
    #1;

    // Reset mid-stream at phase 2 with the buffer full; buffered words must vanish
    do_reset();
    send({10'h155, 10'h0F0, 10'h333});
    send({10'h2CC, 10'h3C3, 10'h0AA});
    send({10'h1E1, 10'h111, 10'h222});
    din = {10'h3EE, 10'h0DD, 10'h155};
    wait_ph(3'd2);
    chk("mid_ready_before", 32'(din_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", 32'(dout), 32'h0);
    chk("mid_rst_ready", 32'(din_ready), 32'h1);
    chk("mid_rst_first", 32'(dout_first), 32'h1);
    din_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
